trap_ctrl: RTL and testbench
============================

// Module: trap_ctrl
// PURPOSE
//  Machine-mode trap sequencer, directly downstream of the CSR file. Consumes mtvec/mepc/mstatus.MIE/mie from the CSRs and
//  exception/MRET requests from execute. Synchronises raw interrupt lines into mip bits. On trap entry or MRET it flushes
//  and drains the pipeline, then issues one redirect plus the CSR update strobes (mepc/mcause/mtval/mstatus) back to the CSRs.
// PARAMETERS
//  XLEN         64  datapath width
//  SYNC_STAGES  2   flops per interrupt-line synchroniser (>=2)
// PORTS
//  clk                 in   1     single clock, rising edge
//  reset               in   1     asynchronous, active-high
//  exc_valid_in        in   1     execute reports synchronous exception
//  exc_cause_in        in   4     exception code (mcause[3:0])
//  exc_pc_in           in   XLEN  PC of faulting instr
//  exc_tval_in         in   XLEN  fault value for mtval
//  mret_in             in   1     execute reports MRET
//  next_pc_in          in   XLEN  PC of oldest unretired instr (mepc for interrupts)
//  irq_ext_in/irq_timer_in/irq_sw_in  in 1 each  asynchronous level interrupt lines
//  mstatus_mie_in      in   1     global M interrupt enable
//  mie_meie_in/mie_mtie_in/mie_msie_in  in 1 each  per-source enables
//  mtvec_in            in   XLEN  [XLEN-1:2] base, [0] mode (1 = vectored)
//  mepc_in             in   XLEN  MRET target
//  drain_done_in       in   1     pipeline empty, no stores in flight
//  mip_meip_out/mip_mtip_out/mip_msip_out  out 1 each  synchronised pending bits, to CSR mip
//  flush_out           out  1     one-cycle pulse: kill all younger instrs
//  stall_out           out  1     hold fetch/decode while sequencing
//  redirect_valid_out  out  1     one-cycle pulse: load redirect_pc_out into fetch PC
//  redirect_pc_out     out  XLEN  redirect target
//  trap_we_out         out  1     one-cycle pulse: CSRs load the three values below and set MPIE<=MIE, MIE<=0
//  trap_mepc_out/trap_mcause_out/trap_mtval_out  out XLEN each  values written on trap_we_out
//  mret_we_out         out  1     one-cycle pulse: CSRs set MIE<=MPIE, MPIE<=1
// BEHAVIOUR
//  - Reset: state IDLE; all synchroniser flops, latched regs and every output 0. Reset mid-sequence aborts to IDLE, no strobes.
//  - mip_*_out = irq line after SYNC_STAGES clk edges; level, no latching. Clearing is by the source only.
//  - irq_take (IDLE only) = mstatus_mie_in & |{meip&meie, msip&msie, mtip&mtie}. Priority MEI(11) > MSI(3) > MTI(7).
//  - Event priority in IDLE, same cycle: exc_valid_in > irq_take > mret_in. Losers are dropped (pipeline is flushed anyway).
//  - States IDLE -> DRAIN -> REDIRECT -> IDLE.
//    IDLE: on event at edge t, latch kind/cause/pc/tval and go to DRAIN.
//    DRAIN: flush_out=1 in the first DRAIN cycle only. Stay in DRAIN until drain_done_in=1 is sampled.
//      drain_done_in is sampled from the first DRAIN cycle on, so the minimum sequence is 1 DRAIN cycle + 1 REDIRECT cycle.
//    REDIRECT: redirect_valid_out=1 for exactly 1 cycle, then back to IDLE.
//      trap_we_out=1 on exception/interrupt; mret_we_out=1 on MRET.
//  - stall_out=1 in DRAIN and REDIRECT; 0 in IDLE. exc/mret/irq inputs are ignored outside IDLE.
//  - Exception: mepc=exc_pc_in, mcause={1'b0, zero-ext code}, mtval=exc_tval_in, pc={mtvec[XLEN-1:2],2'b00}.
//  - Interrupt: mepc=next_pc_in, mcause={1'b1, zero-ext code}, mtval=0.
//    pc=base if mtvec[0]=0, else base+(code<<2). Add in XLEN bits, wrap mod 2^XLEN.
//  - MRET: pc={mepc_in[XLEN-1:2],2'b00}. mepc_in is sampled at event acceptance.
//  - Outputs in IDLE: redirect_pc_out and trap_* values hold their last latched values. Consumers qualify them by the strobes.
//  - Back-to-back: an irq still pending after MRET may be taken on the first IDLE cycle after REDIRECT.
// STRUCTURE
//  - trap_pkg: state enum {IDLE,DRAIN,REDIRECT}, event-kind enum {EV_EXC,EV_IRQ,EV_MRET},
//    interrupt codes IRQ_MSI=3, IRQ_MTI=7, IRQ_MEI=11.
//  - Sub-module irq_sync (param SYNC_STAGES; async reset to 0), instantiated once per interrupt line.
//  - Remainder: priority select, latch registers, FSM and target adder in trap_ctrl.
// TESTING
//  1. Reset held, then released -> all outputs 0.
//     Pulse reset during DRAIN -> IDLE next cycle, no redirect_valid_out or trap_we_out ever seen.
//  2. exc_valid_in, cause 2, pc 0x1000, tval 0xDEAD, mtvec 0x8000_0001, drain_done_in=1 ->
//     flush 1 cycle, then redirect to 0x8000_0000 with mcause 2, mepc 0x1000, mtval 0xDEAD.
//  3. irq_timer_in=1, mie_mtie=1, mstatus_mie=1, mtvec 0x8000_0001, next_pc 0x2004 ->
//     mip_mtip_out after 2 cycles; redirect 0x8000_001C, mcause 0x8000_0000_0000_0007, mepc 0x2004.
//  4. irq_ext_in and irq_timer_in both set, then exc_valid_in in the same cycle as irq_take ->
//     exception taken. A later irq selects cause 11, not 7.
//  5. mret_in with mepc_in 0x3002 and drain_done_in low for 5 cycles ->
//     stall_out high 6 cycles, redirect 0x3000, mret_we_out 1 cycle, trap_we_out never.
//  6. mstatus_mie_in=0 with all irqs pending and enabled for 100 cycles -> no flush;
//     raise mstatus_mie_in -> trap with cause 11 within 1 cycle.

Source files
------------

// File: rtl/trap_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    EV_EXC  = 2'd0,
    EV_IRQ  = 2'd1,
    EV_MRET = 2'd2
  } ev_kind_t;

  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  // Fixed interrupt priority: external > software > timer.
  function automatic logic [3:0] irq_code(input logic ei, input logic si);
    if (ei) begin
      return IRQ_MEI;
    end else if (si) begin
      return IRQ_MSI;
    end else begin
      return IRQ_MTI;
    end
  endfunction

endpackage

// File: rtl/trap_ctrl_irq_sync.sv
// Multi-flop synchroniser bringing one asynchronous interrupt line into the clk domain.
module irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic irq_in,
  output logic sync_out
);

  logic [SYNC_STAGES-1:0] sync_r;

  // Shift the raw line through the synchroniser chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], irq_in};
    end
  end

  assign sync_out = sync_r[SYNC_STAGES-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: accepts exception/interrupt/MRET, flushes and drains
// the pipeline, then issues a single redirect plus the matching CSR update strobe.
import trap_pkg::*;

module trap_ctrl #(
  parameter int XLEN        = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exc_valid_in,
  input  logic [3:0]      exc_cause_in,
  input  logic [XLEN-1:0] exc_pc_in,
  input  logic [XLEN-1:0] exc_tval_in,
  input  logic            mret_in,
  input  logic [XLEN-1:0] next_pc_in,
  input  logic            irq_ext_in,
  input  logic            irq_timer_in,
  input  logic            irq_sw_in,
  input  logic            mstatus_mie_in,
  input  logic            mie_meie_in,
  input  logic            mie_mtie_in,
  input  logic            mie_msie_in,
  input  logic [XLEN-1:0] mtvec_in,
  input  logic [XLEN-1:0] mepc_in,
  input  logic            drain_done_in,
  output logic            mip_meip_out,
  output logic            mip_mtip_out,
  output logic            mip_msip_out,
  output logic            flush_out,
  output logic            stall_out,
  output logic            redirect_valid_out,
  output logic [XLEN-1:0] redirect_pc_out,
  output logic            trap_we_out,
  output logic [XLEN-1:0] trap_mepc_out,
  output logic [XLEN-1:0] trap_mcause_out,
  output logic [XLEN-1:0] trap_mtval_out,
  output logic            mret_we_out
);

  state_t          state_r;
  ev_kind_t        kind_r;
  logic            ei_s, si_s, ti_s, irq_take_s;
  logic [3:0]      irq_code_s;
  logic [XLEN-1:0] base_s, irq_pc_s;
  logic            acc_valid_s;
  ev_kind_t        acc_kind_s;
  logic [XLEN-1:0] acc_pc_s, acc_mepc_s, acc_mcause_s, acc_mtval_s;
  logic            unused_s;

  assign unused_s = ^{mtvec_in[1], mepc_in[1:0]};

  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
    .clk(clk), .reset(reset), .irq_in(irq_ext_in), .sync_out(mip_meip_out));
  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_timer (
    .clk(clk), .reset(reset), .irq_in(irq_timer_in), .sync_out(mip_mtip_out));
  irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sw (
    .clk(clk), .reset(reset), .irq_in(irq_sw_in), .sync_out(mip_msip_out));

  // Event selection and trap target computation for the IDLE acceptance decision.
  always_comb begin
    ei_s       = mip_meip_out & mie_meie_in;
    si_s       = mip_msip_out & mie_msie_in;
    ti_s       = mip_mtip_out & mie_mtie_in;
    irq_take_s = mstatus_mie_in & (ei_s | si_s | ti_s);
    irq_code_s = irq_code(ei_s, si_s);
    base_s     = {mtvec_in[XLEN-1:2], 2'b00};
    if (mtvec_in[0]) begin
      irq_pc_s = base_s + {{(XLEN-6){1'b0}}, irq_code_s, 2'b00};
    end else begin
      irq_pc_s = base_s;
    end

    acc_valid_s  = 1'b0;
    acc_kind_s   = EV_EXC;
    acc_pc_s     = base_s;
    acc_mepc_s   = exc_pc_in;
    acc_mcause_s = {{(XLEN-4){1'b0}}, exc_cause_in};
    acc_mtval_s  = exc_tval_in;
    if (exc_valid_in) begin
      acc_valid_s = 1'b1;
    end else if (irq_take_s) begin
      acc_valid_s  = 1'b1;
      acc_kind_s   = EV_IRQ;
      acc_pc_s     = irq_pc_s;
      acc_mepc_s   = next_pc_in;
      acc_mcause_s = {1'b1, {(XLEN-5){1'b0}}, irq_code_s};
      acc_mtval_s  = {XLEN{1'b0}};
    end else if (mret_in) begin
      acc_valid_s = 1'b1;
      acc_kind_s  = EV_MRET;
      acc_pc_s    = {mepc_in[XLEN-1:2], 2'b00};
    end else begin
      acc_valid_s = 1'b0;
    end
  end

  // Sequencer FSM with registered strobes and latched redirect/CSR values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r            <= IDLE;
      kind_r             <= EV_EXC;
      flush_out          <= 1'b0;
      stall_out          <= 1'b0;
      redirect_valid_out <= 1'b0;
      redirect_pc_out    <= {XLEN{1'b0}};
      trap_we_out        <= 1'b0;
      trap_mepc_out      <= {XLEN{1'b0}};
      trap_mcause_out    <= {XLEN{1'b0}};
      trap_mtval_out     <= {XLEN{1'b0}};
      mret_we_out        <= 1'b0;
    end else begin
      flush_out          <= 1'b0;
      redirect_valid_out <= 1'b0;
      trap_we_out        <= 1'b0;
      mret_we_out        <= 1'b0;
      case (state_r)
        IDLE: begin
          if (acc_valid_s) begin
            state_r         <= DRAIN;
            kind_r          <= acc_kind_s;
            flush_out       <= 1'b1;
            stall_out       <= 1'b1;
            redirect_pc_out <= acc_pc_s;
            // MRET leaves the trap CSR values untouched; they are never strobed for it.
            if (acc_kind_s != EV_MRET) begin
              trap_mepc_out   <= acc_mepc_s;
              trap_mcause_out <= acc_mcause_s;
              trap_mtval_out  <= acc_mtval_s;
            end
          end else begin
            stall_out <= 1'b0;
          end
        end
        DRAIN: begin
          if (drain_done_in) begin
            state_r            <= REDIRECT;
            redirect_valid_out <= 1'b1;
            trap_we_out        <= (kind_r != EV_MRET);
            mret_we_out        <= (kind_r == EV_MRET);
          end
        end
        REDIRECT: begin
          state_r   <= IDLE;
          stall_out <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          stall_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Randomised bench for trap_ctrl against a cycle-level behavioural model, plus directed scenarios.
module tb_trap_ctrl;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_valid_in, mret_in, drain_done_in;
  logic [3:0]  exc_cause_in;
  logic [63:0] exc_pc_in, exc_tval_in, next_pc_in, mtvec_in, mepc_in;
  logic        irq_ext_in, irq_timer_in, irq_sw_in;
  logic        mstatus_mie_in, mie_meie_in, mie_mtie_in, mie_msie_in;
  logic        mip_meip_out, mip_mtip_out, mip_msip_out;
  logic        flush_out, stall_out, redirect_valid_out, trap_we_out, mret_we_out;
  logic [63:0] redirect_pc_out, trap_mepc_out, trap_mcause_out, trap_mtval_out;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  int          phase;
  logic        m_mret;
  logic [63:0] m_pc, m_mepc, m_mcause, m_mtval;
  logic        e_flush, e_stall, e_rv, e_twe, e_mwe;
  logic [2:0]  sync_q[$];

  trap_ctrl #(.XLEN(64), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(reset),
    .exc_valid_in(exc_valid_in), .exc_cause_in(exc_cause_in), .exc_pc_in(exc_pc_in),
    .exc_tval_in(exc_tval_in), .mret_in(mret_in), .next_pc_in(next_pc_in),
    .irq_ext_in(irq_ext_in), .irq_timer_in(irq_timer_in), .irq_sw_in(irq_sw_in),
    .mstatus_mie_in(mstatus_mie_in), .mie_meie_in(mie_meie_in), .mie_mtie_in(mie_mtie_in),
    .mie_msie_in(mie_msie_in), .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .drain_done_in(drain_done_in),
    .mip_meip_out(mip_meip_out), .mip_mtip_out(mip_mtip_out), .mip_msip_out(mip_msip_out),
    .flush_out(flush_out), .stall_out(stall_out), .redirect_valid_out(redirect_valid_out),
    .redirect_pc_out(redirect_pc_out), .trap_we_out(trap_we_out),
    .trap_mepc_out(trap_mepc_out), .trap_mcause_out(trap_mcause_out),
    .trap_mtval_out(trap_mtval_out), .mret_we_out(mret_we_out));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h, expected %h", name, act, exp);
    end
  endtask

  // Each line becomes visible SYNC edges after it was sampled.
  function automatic logic [2:0] mip_exp();
    if (sync_q.size() >= SYNC) return sync_q[SYNC-1];
    else return 3'b000;
  endfunction

  task automatic model_clear();
    phase = 0;
    sync_q.delete();
    e_flush = 1'b0; e_stall = 1'b0; e_rv = 1'b0; e_twe = 1'b0; e_mwe = 1'b0;
  endtask

  task automatic model_edge();
    logic [2:0]  mip, pend;
    logic [63:0] base;
    int          code;
    mip = mip_exp();
    e_flush = 1'b0; e_rv = 1'b0; e_twe = 1'b0; e_mwe = 1'b0;
    if (reset) begin
      model_clear();
    end else begin
      sync_q.push_front({irq_ext_in, irq_timer_in, irq_sw_in});
      if (sync_q.size() > SYNC) void'(sync_q.pop_back());
      pend = mip & {mie_meie_in, mie_mtie_in, mie_msie_in};
      base = mtvec_in & ~64'h3;
      if (phase == 0) begin
        if (exc_valid_in) begin
          phase = 1; e_flush = 1'b1; m_mret = 1'b0;
          m_mepc = exc_pc_in; m_mcause = 64'(exc_cause_in); m_mtval = exc_tval_in; m_pc = base;
        end else if (mstatus_mie_in && pend != 3'b000) begin
          code = pend[2] ? 11 : (pend[0] ? 3 : 7);
          phase = 1; e_flush = 1'b1; m_mret = 1'b0;
          m_mepc = next_pc_in; m_mcause = 64'h8000_0000_0000_0000 + 64'(code); m_mtval = 64'd0;
          m_pc = base + (mtvec_in[0] ? 64'(code) * 4 : 64'd0);
        end else if (mret_in) begin
          phase = 1; e_flush = 1'b1; m_mret = 1'b1; m_pc = mepc_in & ~64'h3;
        end
      end else if (phase == 1) begin
        if (drain_done_in) begin
          phase = 2; e_rv = 1'b1; e_twe = !m_mret; e_mwe = m_mret;
        end
      end else begin
        phase = 0;
      end
      e_stall = (phase != 0);
    end
  endtask

  task automatic compare();
    logic [2:0] m;
    m = mip_exp();
    chk("mip_meip", 64'(mip_meip_out), 64'(m[2]));
    chk("mip_mtip", 64'(mip_mtip_out), 64'(m[1]));
    chk("mip_msip", 64'(mip_msip_out), 64'(m[0]));
    chk("flush", 64'(flush_out), 64'(e_flush));
    chk("stall", 64'(stall_out), 64'(e_stall));
    chk("redirect_valid", 64'(redirect_valid_out), 64'(e_rv));
    chk("trap_we", 64'(trap_we_out), 64'(e_twe));
    chk("mret_we", 64'(mret_we_out), 64'(e_mwe));
    if (e_rv) chk("redirect_pc", redirect_pc_out, m_pc);
    if (e_twe) begin
      chk("trap_mepc", trap_mepc_out, m_mepc);
      chk("trap_mcause", trap_mcause_out, m_mcause);
      chk("trap_mtval", trap_mtval_out, m_mtval);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1;
    #1;
    model_clear();
    compare();
    chk("rst_redirect_pc", redirect_pc_out, 64'd0);
    chk("rst_trap_mepc", trap_mepc_out, 64'd0);
    chk("rst_trap_mcause", trap_mcause_out, 64'd0);
    chk("rst_trap_mtval", trap_mtval_out, 64'd0);
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic quiet();
    exc_valid_in = 1'b0; mret_in = 1'b0; drain_done_in = 1'b1;
    irq_ext_in = 1'b0; irq_timer_in = 1'b0; irq_sw_in = 1'b0;
    mie_meie_in = 1'b0; mie_mtie_in = 1'b0; mie_msie_in = 1'b0; mstatus_mie_in = 1'b0;
  endtask

  initial begin
    int cnt;
    reset = 1'b1;
    exc_cause_in = 4'd0; exc_pc_in = 64'd0; exc_tval_in = 64'd0;
    next_pc_in = 64'd0; mtvec_in = 64'd0; mepc_in = 64'd0;
    quiet();
    do_reset(3);
    step();

    // Reset in the middle of DRAIN aborts the sequence with no strobes.
    exc_valid_in = 1'b1; exc_cause_in = 4'd4; drain_done_in = 1'b0;
    step();
    chk("abort_flush", 64'(flush_out), 64'd1);
    exc_valid_in = 1'b0;
    do_reset(1);
    drain_done_in = 1'b1;
    cnt = 0;
    repeat (4) begin
      step();
      if (redirect_valid_out || trap_we_out) cnt++;
    end
    chk("abort_no_strobe", 64'(cnt), 64'd0);

    // Exception with vectored mtvec still goes to the base.
    mtvec_in = 64'h8000_0001; exc_valid_in = 1'b1; exc_cause_in = 4'd2;
    exc_pc_in = 64'h1000; exc_tval_in = 64'hDEAD;
    step();
    chk("exc_flush", 64'(flush_out), 64'd1);
    exc_valid_in = 1'b0;
    step();
    chk("exc_redirect_pc", redirect_pc_out, 64'h8000_0000);
    chk("exc_mcause", trap_mcause_out, 64'd2);
    chk("exc_mepc", trap_mepc_out, 64'h1000);
    chk("exc_mtval", trap_mtval_out, 64'hDEAD);
    step();
    chk("exc_stall_done", 64'(stall_out), 64'd0);

    // Timer interrupt, vectored.
    irq_timer_in = 1'b1; mie_mtie_in = 1'b1; mstatus_mie_in = 1'b1; next_pc_in = 64'h2004;
    step();
    chk("mtip_after1", 64'(mip_mtip_out), 64'd0);
    step();
    chk("mtip_after2", 64'(mip_mtip_out), 64'd1);
    step();
    chk("irq_flush", 64'(flush_out), 64'd1);
    mie_mtie_in = 1'b0; irq_timer_in = 1'b0;
    step();
    chk("irq_redirect_pc", redirect_pc_out, 64'h8000_001C);
    chk("irq_mcause", trap_mcause_out, 64'h8000_0000_0000_0007);
    chk("irq_mepc", trap_mepc_out, 64'h2004);
    repeat (3) step();

    // Exception beats a simultaneous interrupt; the interrupt then resolves to MEI.
    irq_ext_in = 1'b1; irq_timer_in = 1'b1; mie_meie_in = 1'b1; mie_mtie_in = 1'b1;
    repeat (2) step();
    exc_valid_in = 1'b1; exc_cause_in = 4'd5;
    step();
    exc_valid_in = 1'b0;
    step();
    chk("prio_exc_mcause", trap_mcause_out, 64'd5);
    step();
    step();
    chk("prio_irq_flush", 64'(flush_out), 64'd1);
    step();
    chk("prio_irq_mcause", trap_mcause_out, 64'h8000_0000_0000_000B);
    quiet();
    repeat (3) step();

    // MRET with a slow drain.
    mret_in = 1'b1; mepc_in = 64'h3002; drain_done_in = 1'b0;
    cnt = 0;
    step();
    if (stall_out) cnt++;
    mret_in = 1'b0;
    repeat (4) begin
      step();
      if (stall_out) cnt++;
    end
    drain_done_in = 1'b1;
    step();
    if (stall_out) cnt++;
    chk("mret_redirect_pc", redirect_pc_out, 64'h3000);
    chk("mret_we", 64'(mret_we_out), 64'd1);
    chk("mret_no_trap_we", 64'(trap_we_out), 64'd0);
    step();
    if (stall_out) cnt++;
    chk("mret_stall_cycles", 64'(cnt), 64'd6);

    // Global enable gates all interrupts.
    irq_ext_in = 1'b1; irq_timer_in = 1'b1; irq_sw_in = 1'b1;
    mie_meie_in = 1'b1; mie_mtie_in = 1'b1; mie_msie_in = 1'b1;
    cnt = 0;
    repeat (100) begin
      step();
      if (flush_out) cnt++;
    end
    chk("mie0_no_flush", 64'(cnt), 64'd0);
    mstatus_mie_in = 1'b1;
    step();
    chk("mie1_flush", 64'(flush_out), 64'd1);
    step();
    chk("mie1_mcause", trap_mcause_out, 64'h8000_0000_0000_000B);
    quiet();
    repeat (3) step();

    // Randomised traffic.
    for (int i = 0; i < 4000; i++) begin
      exc_valid_in  = ($urandom_range(0, 5) == 0);
      exc_cause_in  = 4'($urandom);
      exc_pc_in     = {$urandom, $urandom};
      exc_tval_in   = {$urandom, $urandom};
      mret_in       = ($urandom_range(0, 7) == 0);
      next_pc_in    = {$urandom, $urandom};
      mepc_in       = {$urandom, $urandom};
      drain_done_in = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) irq_ext_in = ~irq_ext_in;
      if ($urandom_range(0, 7) == 0) irq_timer_in = ~irq_timer_in;
      if ($urandom_range(0, 7) == 0) irq_sw_in = ~irq_sw_in;
      if ($urandom_range(0, 15) == 0) begin
        mie_meie_in = 1'($urandom); mie_mtie_in = 1'($urandom); mie_msie_in = 1'($urandom);
      end
      mstatus_mie_in = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 3))
        0: mtvec_in = {$urandom, $urandom};
        1: mtvec_in = 64'h8000_0001;
        2: mtvec_in = 64'hFFFF_FFFF_FFFF_FFF1;
        default: mtvec_in = {$urandom, $urandom} | 64'h1;
      endcase
      if ($urandom_range(0, 299) == 0) do_reset(1);
      else step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
